// File: rtl/load_store_unit_pkg.sv
// Shared types and widths for the load/store unit and its helpers.
// The FSM state encoding is fixed so waveforms and debug tooling can decode it.
package load_store_unit_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_timeout_counter.sv
// Wait-cycle counter for the memory handshake.
// expired marks the TIMEOUT-th consecutive WAIT cycle that has no acknowledge.
module lsu_timeout_counter
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The count equals the number of WAIT cycles already spent, so the current cycle is count_q+1.
    assign expired = enable && (count_q == LIMIT);

    // Next count: clear wins, then increment with a saturating guard.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: runs a req/ack handshake with data memory and
// returns load data to the register file as a one-cycle memLoad strobe.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [SEL_W-1:0]  dest_sel,
    input  logic [15:0]       addr_in,
    input  logic [15:0]       store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              memLoad,
    output logic [SEL_W-1:0]  reg_sel,
    output logic [15:0]       write_data,
    output logic              busy,
    output logic              fault
);

    lsu_state_e          state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [SEL_W-1:0]    dest_q, dest_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_load_q, mem_load_d;
    logic [SEL_W-1:0]    reg_sel_q, reg_sel_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic                wait_expired_s;
    logic                cnt_clear_s;
    logic                cnt_enable_s;

    assign cnt_clear_s  = (state_q == ST_REQ);
    assign cnt_enable_s = (state_q == ST_WAIT) && !mem_ack;

    lsu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (wait_expired_s)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        dest_d       = dest_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_load_d   = 1'b0;
        reg_sel_d    = reg_sel_q;
        write_data_d = write_data_q;
        busy_d       = busy_q;
        fault_d      = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d  = is_store;
                    dest_d      = dest_sel;
                    mem_addr_d  = addr_in[ADDR_W-1:0];
                    mem_wdata_d = store_data;
                    busy_d      = 1'b1;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_d = 1'b1;
                mem_we_d  = is_store_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack on the expiry cycle still completes the access.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (is_store_q) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        write_data_d = mem_rdata;
                        mem_load_d   = 1'b1;
                        reg_sel_d    = dest_q;
                        state_d      = ST_WB;
                    end
                end else if (wait_expired_s) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WB: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            dest_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_load_q   <= 1'b0;
            reg_sel_q    <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            dest_q       <= dest_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_load_q   <= mem_load_d;
            reg_sel_q    <= reg_sel_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign memLoad    = mem_load_q;
    assign reg_sel    = reg_sel_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule
